// File: rtl/pingpong_transpose_buffer.sv
// pingpong_transpose_buffer: double-banked NxN transpose buffer for the 2-D DCT/IDCT path.
// Rows are written into one bank while the other bank drains, so a continuous stream
// runs at full rate. TRANSPOSE=1 emits column c on beat c; TRANSPOSE=0 emits row r on beat r.
// Optional feature macro: PINGPONG_TPBUF_BLKCNT_EN (saturating count of drained blocks on
// blk_count); when undefined, blk_count is tied to zero.
module pingpong_transpose_buffer #(
    parameter int unsigned N         = 8,
    parameter int unsigned W         = 9,
    parameter int unsigned TRANSPOSE = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N*W-1:0]   in_row,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N*W-1:0]   out_vec,
    output logic             out_first,
    output logic             out_last,
    output logic [15:0]      blk_count
);

    localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
    localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

    typedef enum logic [1:0] {
        BS_EMPTY    = 2'd0,
        BS_FILLING  = 2'd1,
        BS_FULL     = 2'd2,
        BS_DRAINING = 2'd3
    } bank_state_t;

    bank_state_t     r_state [0:1];
    logic            r_wbank;
    logic            r_rbank;
    logic [AW-1:0]   r_wrow;
    logic [AW-1:0]   r_rbeat;
    logic [W-1:0]    r_mem [0:1][0:N-1][0:N-1];

    logic            w_in_ready;
    logic            w_out_valid;
    logic            w_wr_fire;
    logic            w_rd_fire;

    // Handshake qualifiers derive from registered bank state only.
    assign w_in_ready  = (r_state[r_wbank] == BS_EMPTY) || (r_state[r_wbank] == BS_FILLING);
    assign w_out_valid = (r_state[r_rbank] == BS_FULL)  || (r_state[r_rbank] == BS_DRAINING);
    assign w_wr_fire   = in_valid && w_in_ready;
    assign w_rd_fire   = w_out_valid && out_ready;

    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_first = w_out_valid && (r_rbeat == '0);
    assign out_last  = w_out_valid && (r_rbeat == LAST_IDX);

    // Bank state machines plus write/read pointers; write and read never target the same bank.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state[0] <= BS_EMPTY;
            r_state[1] <= BS_EMPTY;
            r_wbank    <= 1'b0;
            r_rbank    <= 1'b0;
            r_wrow     <= '0;
            r_rbeat    <= '0;
        end else begin
            if (w_wr_fire) begin
                if (r_wrow == LAST_IDX) begin
                    r_wrow           <= '0;
                    r_wbank          <= ~r_wbank;
                    r_state[r_wbank] <= BS_FULL;
                end else begin
                    r_wrow           <= r_wrow + AW'(1);
                    r_state[r_wbank] <= BS_FILLING;
                end
            end
            if (w_rd_fire) begin
                if (r_rbeat == LAST_IDX) begin
                    r_rbeat          <= '0;
                    r_rbank          <= ~r_rbank;
                    r_state[r_rbank] <= BS_EMPTY;
                end else begin
                    r_rbeat          <= r_rbeat + AW'(1);
                    r_state[r_rbank] <= BS_DRAINING;
                end
            end
        end
    end

    // Row storage; data registers carry no reset.
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int j = 0; j < int'(N); j++) begin
                r_mem[r_wbank][r_wrow][j] <= in_row[j*W +: W];
            end
        end
    end

    // Output mux: column of the draining bank, or its row in pass-through mode.
    for (genvar gi = 0; gi < N; gi++) begin : g_out
        if (TRANSPOSE != 0) begin : g_col
            assign out_vec[gi*W +: W] = r_mem[r_rbank][gi][r_rbeat];
        end else begin : g_row
            assign out_vec[gi*W +: W] = r_mem[r_rbank][r_rbeat][gi];
        end
    end

`ifdef PINGPONG_TPBUF_BLKCNT_EN
    logic [15:0] r_blk_count;

    // Saturating count of blocks whose last beat has been accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_blk_count <= 16'h0000;
        end else if (w_rd_fire && (r_rbeat == LAST_IDX) && (r_blk_count != 16'hFFFF)) begin
            r_blk_count <= r_blk_count + 16'd1;
        end
    end

    assign blk_count = r_blk_count;
`else
    assign blk_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pingpong_transpose_buffer.sv
// Directed bench for pingpong_transpose_buffer: one TRANSPOSE=1 and one TRANSPOSE=0 instance
// (N=8, W=12) share the same stimulus; expected vectors come from the element formula
// base + 64*block + 8*row + col.
module tb_pingpong_transpose_buffer;

    localparam int unsigned N  = 8;
    localparam int unsigned W  = 12;
    localparam int unsigned VW = N * W;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [VW-1:0] in_row;
    logic          out_ready;

    logic          in_ready_a, out_valid_a, out_first_a, out_last_a;
    logic [VW-1:0] out_vec_a;
    logic [15:0]   blk_count_a;
    logic          in_ready_b, out_valid_b, out_first_b, out_last_b;
    logic [VW-1:0] out_vec_b;
    logic [15:0]   blk_count_b;

    pingpong_transpose_buffer #(.N(N), .W(W), .TRANSPOSE(1)) u_dut_t (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_a), .in_row(in_row),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_vec(out_vec_a),
        .out_first(out_first_a), .out_last(out_last_a), .blk_count(blk_count_a)
    );

    pingpong_transpose_buffer #(.N(N), .W(W), .TRANSPOSE(0)) u_dut_n (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_b), .in_row(in_row),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_vec(out_vec_b),
        .out_first(out_first_b), .out_last(out_last_b), .blk_count(blk_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int base  = 0;
    int tx, rx_a, rx_b, tx_lim, cyc;
    int first_valid_cyc, last_row_cyc, gaps, gap_tgt;
    int drops_a, drops_b, first_drop_a, first_drop_b;
    int rdy_mode, rdy_lim;
    int exp_blk;

    task automatic check(input string tag, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [W-1:0] elem(input int blk, input int r, input int c);
        return W'(base + 64*blk + 8*r + c);
    endfunction

    function automatic logic [VW-1:0] row_val(input int g);
        logic [VW-1:0] v;
        for (int c = 0; c < int'(N); c++) v[c*W +: W] = elem(g / 8, g % 8, c);
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_col(input int q);
        logic [VW-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i*W +: W] = elem(q / 8, i, q % 8);
        return v;
    endfunction

    function automatic logic [VW-1:0] exp_row(input int q);
        logic [VW-1:0] v;
        for (int i = 0; i < int'(N); i++) v[i*W +: W] = elem(q / 8, q % 8, i);
        return v;
    endfunction

    // One cycle: sample outputs at the falling edge, check them, then drive the next inputs.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (out_valid_a) begin
            check("vec_col", out_vec_a, exp_col(rx_a));
            check("first_col", VW'(out_first_a), VW'(rx_a % 8 == 0));
            check("last_col", VW'(out_last_a), VW'(rx_a % 8 == 7));
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end else if (first_valid_cyc >= 0 && rx_a < gap_tgt) begin
            gaps++;
        end
        if (out_valid_b) begin
            check("vec_row", out_vec_b, exp_row(rx_b));
            check("first_row", VW'(out_first_b), VW'(rx_b % 8 == 0));
            check("last_row", VW'(out_last_b), VW'(rx_b % 8 == 7));
        end
        in_valid  = (tx < tx_lim);
        in_row    = in_valid ? row_val(tx) : '0;
        out_ready = (rdy_mode == 1) || (rdy_mode == 2 && rx_a < rdy_lim);
        if (in_valid && !in_ready_a) begin
            drops_a++;
            if (first_drop_a < 0) first_drop_a = tx;
        end
        if (in_valid && !in_ready_b) begin
            drops_b++;
            if (first_drop_b < 0) first_drop_b = tx;
        end
        if (in_valid && in_ready_a) begin
            if (tx % 8 == 7) last_row_cyc = cyc;
            tx++;
        end
        if (out_valid_a && out_ready) rx_a++;
        if (out_valid_b && out_ready) rx_b++;
    endtask

    task automatic run_until(input int tgt_tx, input int tgt_rx, input int budget);
        int n = 0;
        while ((tx < tgt_tx || rx_a < tgt_rx || rx_b < tgt_rx) && n < budget) begin
            step();
            n++;
        end
    endtask

    // Pulse reset for one edge and check the post-reset outputs on the following cycle.
    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", VW'(in_ready_a), VW'(1));
        check("rst_out_valid", VW'(out_valid_a), VW'(0));
        check("rst_out_first", VW'(out_first_a), VW'(0));
        check("rst_out_last", VW'(out_last_a), VW'(0));
        check("rst_blk_count", VW'(blk_count_a), VW'(0));
        check("rst_in_ready_n", VW'(in_ready_b), VW'(1));
        check("rst_out_valid_n", VW'(out_valid_b), VW'(0));
        reset = 1'b0;
        tx = 0; rx_a = 0; rx_b = 0; tx_lim = 0; cyc = 0;
        first_valid_cyc = -1; last_row_cyc = -1; gaps = 0; gap_tgt = 0;
        drops_a = 0; drops_b = 0; first_drop_a = -1; first_drop_b = -1;
        rdy_mode = 0; rdy_lim = 0;
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
`ifdef PINGPONG_TPBUF_BLKCNT_EN
        exp_blk = 1;
`else
        exp_blk = 0;
`endif

        // Single block with out_ready held high.
        do_reset();
        base = 0; tx_lim = 8; rdy_mode = 1; gap_tgt = 8;
        run_until(8, 8, 40);
        check("single_done", VW'(rx_a), VW'(8));
        check("single_latency", VW'(first_valid_cyc - last_row_cyc), VW'(1));
        check("single_gaps", VW'(gaps), VW'(0));

        // Four back-to-back blocks at full rate.
        do_reset();
        base = 0; tx_lim = 32; rdy_mode = 1; gap_tgt = 32;
        run_until(32, 32, 100);
        check("stream_done", VW'(rx_a), VW'(32));
        check("stream_done_n", VW'(rx_b), VW'(32));
        check("stream_in_drops", VW'(drops_a), VW'(0));
        check("stream_in_drops_n", VW'(drops_b), VW'(0));
        check("stream_gaps", VW'(gaps), VW'(0));

        // Backpressure: three blocks offered while the output is stalled.
        do_reset();
        base = 0; tx_lim = 24; rdy_mode = 0;
        for (int n = 0; n < 40 && first_drop_a < 0; n++) step();
        check("bp_drop_at", VW'(first_drop_a), VW'(16));
        check("bp_drop_at_n", VW'(first_drop_b), VW'(16));
        for (int n = 0; n < 4; n++) step();
        check("bp_tx_held", VW'(tx), VW'(16));
        check("bp_valid", VW'(out_valid_a), VW'(1));
        check("bp_col0", out_vec_a, exp_col(0));
        rdy_mode = 1;
        run_until(24, 24, 150);
        check("bp_done", VW'(rx_a), VW'(24));
        check("bp_done_n", VW'(rx_b), VW'(24));
        @(negedge clk);
        check("bp_blk_count", VW'(blk_count_a), VW'(exp_blk * 3));
        check("bp_blk_count_n", VW'(blk_count_b), VW'(exp_blk * 3));

        // Reset mid-operation: one block partly drained, the next partly filled.
        do_reset();
        base = 0; tx_lim = 13; rdy_mode = 2; rdy_lim = 3;
        run_until(13, 3, 60);
        check("mid_tx", VW'(tx), VW'(13));
        check("mid_rx", VW'(rx_a), VW'(3));
        do_reset();
        base = 512; tx_lim = 8; rdy_mode = 1; gap_tgt = 8;
        run_until(8, 8, 40);
        check("fresh_done", VW'(rx_a), VW'(8));
        check("fresh_done_n", VW'(rx_b), VW'(8));
        @(negedge clk);
        check("fresh_blk_count", VW'(blk_count_a), VW'(exp_blk));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
